// File: rtl/arbiter_client.sv
// arbiter_client: buffers producer beats and requests the shared bus per complete transaction.
// Define ARBITER_CLIENT_BURST_EN to honour wr_last; otherwise every beat is its own transaction.
module arbiter_client #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  request,
    output logic                  hold,
    input  logic                  grant,
    output logic                  bus_valid,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_last
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d, txn_q, txn_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0]      last_mem_q;
    logic                  push, pop, beat_last, head_last;

`ifdef ARBITER_CLIENT_BURST_EN
    assign beat_last = wr_last;
`else
    // wr_last is read but always overridden so each beat closes its transaction
    assign beat_last = wr_last | 1'b1;
`endif

    assign head_last = last_mem_q[rd_ptr_q];
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign overflow  = overflow_q;
    assign request   = (state_q == BURST) | (txn_q != '0);
    assign bus_valid = request & grant;
    assign bus_data  = data_mem_q[rd_ptr_q];
    assign bus_last  = ~empty & head_last;
    assign push      = wr_en & ~full;
    assign pop       = bus_valid;

`ifdef ARBITER_CLIENT_BURST_EN
    assign hold = bus_valid & ~head_last;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        txn_d      = txn_q + (AW+1)'(push & beat_last) - (AW+1)'(pop & head_last);
        overflow_d = overflow_q | (wr_en & full);
        state_d    = state_q;
`ifdef ARBITER_CLIENT_BURST_EN
        if (pop)
            state_d = head_last ? IDLE : BURST;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            txn_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            txn_q      <= txn_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= wr_data;
            last_mem_q[wr_ptr_q] <= beat_last;
        end
    end
endmodule

// File: tb/tb_arbiter_client.sv
// tb_arbiter_client: scoreboard bench comparing arbiter_client against a queue-based model.
// Burst scenarios run only when ARBITER_CLIENT_BURST_EN is defined.
module tb_arbiter_client;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef ARBITER_CLIENT_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          grant = 1'b0;
    logic          full, empty, overflow, request, hold, bus_valid, bus_last;
    logic [DW-1:0] bus_data;

    arbiter_client #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .full(full), .empty(empty), .overflow(overflow), .request(request), .hold(hold),
        .grant(grant), .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
    typedef struct packed {logic req; logic full; logic empty; logic ovf; logic valid;} stat_t;

    beat_t mbuf[$];
    beat_t beat_q[$];
    stat_t stat_q[$];
    int    mtxn = 0;
    bit    mburst = 0, movf = 0;
    int    n_cmp = 0, n_err = 0;
    stat_t ms;
    beat_t mh;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a transaction is requested only once complete; in a burst the client keeps requesting
    task automatic cycle(bit w, logic [DW-1:0] d, bit l, bit g);
        stat_t s;
        beat_t h;
        bit    req, fl, pp;
        @(posedge clk);
        #1;
        wr_en = w; wr_data = d; wr_last = l; grant = g;
        req = mburst || (mtxn > 0);
        fl  = (mbuf.size() == DEPTH);
        pp  = req && g;
        s.req = req; s.full = fl; s.empty = (mbuf.size() == 0); s.ovf = movf; s.valid = pp;
        stat_q.push_back(s);
        if (pp) begin
            h = mbuf.pop_front();
            beat_q.push_back(h);
            if (h.last) begin mtxn--; mburst = 0; end else mburst = 1;
        end
        if (w && !fl) begin
            h.data = d;
            h.last = BURST ? l : 1'b1;
            mbuf.push_back(h);
            if (h.last) mtxn++;
        end else if (w) movf = 1;
    endtask

    task automatic model_clear();
        stat_q.delete(); beat_q.delete(); mbuf.delete();
        mtxn = 0; mburst = 0; movf = 0;
    endtask

    task automatic async_reset(string tag);
        @(posedge clk);
        #3;
        wr_en = 0; grant = 0; rst_n = 0;
        #1;
        chk({tag, "_request"}, request, 0);
        chk({tag, "_hold"}, hold, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_bus_valid"}, bus_valid, 0);
        chk({tag, "_bus_last"}, bus_last, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (rst_n && stat_q.size() > 0) begin
            ms = stat_q.pop_front();
            chk("request", request, ms.req);
            chk("full", full, ms.full);
            chk("empty", empty, ms.empty);
            chk("overflow", overflow, ms.ovf);
            chk("bus_valid", bus_valid, ms.valid);
            if (bus_valid) begin
                if (beat_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat at %0t", bus_data, $time);
                end else begin
                    mh = beat_q.pop_front();
                    chk("bus_data", bus_data, mh.data);
                    chk("bus_last", bus_last, mh.last);
                    chk("hold", hold, BURST && !mh.last);
                end
            end else chk("hold_idle", hold, 0);
        end
    end

    initial begin
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_request", request, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bus_valid", bus_valid, 0);
        rst_n = 1;
        cycle(1, 32'hA5, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
`ifdef ARBITER_CLIENT_BURST_EN
        cycle(1, 32'h1, 0, 0);
        cycle(1, 32'h2, 0, 0);
        cycle(1, 32'h3, 1, 0);
        cycle(0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(1, 32'h11, 0, 0);
        cycle(1, 32'h12, 0, 0);
        cycle(1, 32'h13, 1, 0);
        cycle(0, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 32'h21, 0, 0);
        cycle(1, 32'h22, 0, 0);
        cycle(1, 32'h23, 1, 0);
        repeat (2) cycle(0, 0, 0, 1);
        async_reset("mid_burst");
`else
        cycle(1, 32'h21, 1, 0);
        cycle(1, 32'h22, 1, 0);
        async_reset("mid_fill");
`endif
        for (int i = 0; i < 5; i++) cycle(1, 32'h40 + i, 1, 0);
        cycle(1, 32'h99, 1, 1);
        cycle(0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1);
        async_reset("post_ovf");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rand");
            cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
        repeat (20) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("drain_beats_left", beat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arbiter_client.md
ARBITER_CLIENT -- requirements
Module: arbiter_client

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one bus beat.
REQ-002 Parameter DEPTH, default 4: pending-beat buffer entries; power of two, at least 2.
REQ-003 Port clk  input  1: the single clock; all state on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port wr_en  input  1: push one beat from the local producer.
REQ-006 Port wr_data  input  DATA_WIDTH: beat payload.
REQ-007 Port wr_last  input  1: pushed beat ends its transaction.
REQ-008 Port full  output  1: buffer holds DEPTH beats.
REQ-009 Port empty  output  1: buffer holds 0 beats.
REQ-010 Port overflow  output  1: sticky; a push was dropped.
REQ-011 Port request  output  1: this client's bit of the arbitration unit's requests vector.
REQ-012 Port hold  output  1: drives the arbitration unit's hold input (CAN_HOLD=1 instance).
REQ-013 Port grant  input  1: this client's bit of the arbitration unit's grants vector, valid same cycle as request.
REQ-014 Port bus_valid  output  1: beat presented on the shared bus this cycle.
REQ-015 Port bus_data  output  DATA_WIDTH: head beat payload.
REQ-016 Port bus_last  output  1: head beat's last flag.

Function
REQ-017 Buffer SHALL be a circular FIFO of DEPTH entries {data, last}, count range 0..DEPTH, pointers wrapping modulo DEPTH.
REQ-018 Push SHALL be accepted when wr_en=1 and full=0, even if a pop occurs the same cycle; wr_en=1 with full=1 SHALL drop the beat and set overflow.
REQ-019 A counter txn_cnt (range 0..DEPTH) SHALL count buffered complete transactions: +1 on accepted push with last=1, -1 on popped beat with last=1, unchanged when both occur together.
REQ-020 FSM states IDLE and BURST.
REQ-021 IDLE: request = (txn_cnt != 0); a transaction SHALL never be requested before its last beat is buffered.
REQ-022 Pop SHALL occur when request=1 and grant=1; bus_valid = request & grant, combinational, zero added latency; bus_data/bus_last = head entry.
REQ-023 IDLE to BURST when a popped beat has last=0; BURST to IDLE when a popped beat has last=1; IDLE popped last=1 beat stays IDLE.
REQ-024 BURST: request=1 unconditionally; grant=0 SHALL not pop and SHALL not leave BURST.
REQ-025 hold = bus_valid & ~bus_last: asserted in every granted beat of a multi-beat transaction except its final beat.
REQ-026 grant=1 while request=0 SHALL be ignored (no pop, no state change).
REQ-027 Single-beat transactions SHALL pop one beat per granted cycle, back-to-back while txn_cnt != 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear pointers, count, txn_cnt, overflow and force IDLE; resulting outputs: empty=1, full=0, overflow=0, request=0, hold=0, bus_valid=0, bus_last=0.
REQ-029 Reset mid-burst SHALL discard all buffered beats, including the partial transaction; buffer contents are not cleared.

Configuration
REQ-030 Macro ARBITER_CLIENT_BURST_EN, when defined, SHALL enable multi-beat transactions per REQ-023..REQ-025.
REQ-031 Without ARBITER_CLIENT_BURST_EN every pushed beat SHALL be stored with last=1 (wr_last ignored), hold SHALL be constant 0, BURST SHALL be unreachable.

Verification
REQ-032 Reset, push 0xA5 (last=1), grant tied 1 -> next cycle request=1, bus_valid=1, bus_data=0xA5, hold=0; following cycle empty=1, request=0.
REQ-033 BURST_EN: push 0x1,0x2 (last=0) -> request stays 0; push 0x3 (last=1) -> request=1; grant 1 for 3 cycles -> bus_data 0x1,0x2,0x3, hold 1,1,0.
REQ-034 BURST_EN: mid-burst drop grant 2 cycles -> no pop, request=1, state BURST, bus_valid=0; restore grant -> remaining beats in order.
REQ-035 DEPTH=4, push 5 beats, grant=0 -> full=1 after 4th, 5th dropped, overflow=1 and stays 1 until rst_n=0.
REQ-036 Full buffer, simultaneous push and granted pop -> pop occurs, push dropped, count 3, overflow=1.
REQ-037 Assert rst_n=0 asynchronously between beats 2 and 3 of a 3-beat burst -> request=0, hold=0, empty=1 immediately without a clock edge.
